// File: rtl/call_scheduler.sv
// Elevator call scheduler: latches call buttons, tracks pending stops, runs SCAN direction
// selection, picks the next destination and times the door-open dwell for the floor mover.
module call_scheduler #(
   parameter int unsigned NF          = 6,
   parameter int unsigned DOOR_CYCLES = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [NF-1:0] btn,
   input  logic [NF-1:0] currentF,
   input  logic          isOpen,
   output logic [NF-1:0] requestF,
   output logic [NF-1:0] desF,
   output logic [1:0]    up,
   output logic          isClose
);

   localparam int unsigned CW = $clog2(DOOR_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [NF-1:0] btn_q;
   logic [NF-1:0] pend_q, pend_d;
   logic [NF-1:0] req_q, req_d;
   logic [NF-1:0] des_q, des_d;
   logic [1:0]    up_q, up_d;
   logic          close_q, close_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [NF-1:0] press;
   logic [NF-1:0] serve;
   logic          cf_onehot;
   logic          reopen;
   logic [NF-1:0] above;
   logic [NF-1:0] below;
   logic [NF-1:0] lo_above;
   logic [NF-1:0] hi_below;

   // Pending-stop update, served-stop clearing and door dwell timing
   always_comb begin
      press     = btn & ~btn_q;
      cf_onehot = (currentF != '0) && ((currentF & (currentF - NF'(1))) == '0);
      serve     = cf_onehot ? (currentF & {NF{isOpen}}) : '0;
      pend_d    = (pend_q | press) & ~serve;
      reopen    = cf_onehot && isOpen && ((press & currentF) != '0);

      cnt_d   = cnt_q;
      close_d = 1'b0;
      if (!isOpen || reopen) begin
         cnt_d = '0;
      end else begin
         if (cnt_q < CW'(DOOR_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
         end
         close_d = (cnt_q == CW'(DOOR_CYCLES));
      end
   end

   // Stops strictly above / below the current stop, and the nearest one in each direction
   always_comb begin
      above    = pend_d & ~((currentF << 1) - NF'(1));
      below    = pend_d & (currentF - NF'(1));
      lo_above = above & (~above + NF'(1));
      hi_below = '0;
      for (int i = 0; i < NF; i++) begin
         if (below[i]) begin
            hi_below = NF'(1) << i;
         end
      end
   end

   // SCAN direction FSM with destination / request outputs; frozen while currentF is invalid
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      des_d   = des_q;
      up_d    = up_q;
      if (cf_onehot) begin
         req_d = pend_d;
         case (state_q)
            S_IDLE: begin
               if (above != '0)      state_d = S_UP;
               else if (below != '0) state_d = S_DOWN;
               else                  state_d = S_IDLE;
            end
            S_UP: begin
               if (above != '0)      state_d = S_UP;
               else if (below != '0) state_d = S_DOWN;
               else                  state_d = S_IDLE;
            end
            S_DOWN: begin
               if (below != '0)      state_d = S_DOWN;
               else if (above != '0) state_d = S_UP;
               else                  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
         case (state_d)
            S_UP: begin
               des_d = lo_above;
               up_d  = 2'b10;
            end
            S_DOWN: begin
               des_d = hi_below;
               up_d  = 2'b01;
            end
            default: begin
               des_d = currentF;
               up_d  = 2'b00;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         btn_q   <= '0;
         pend_q  <= '0;
         req_q   <= '0;
         des_q   <= NF'(1);
         up_q    <= 2'b00;
         close_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         btn_q   <= btn;
         pend_q  <= pend_d;
         req_q   <= req_d;
         des_q   <= des_d;
         up_q    <= up_d;
         close_q <= close_d;
         cnt_q   <= cnt_d;
      end
   end

   assign requestF = req_q;
   assign desF     = des_q;
   assign up       = up_q;
   assign isClose  = close_q;

endmodule

// File: tb/tb_call_scheduler.sv
// Self-checking bench for call_scheduler: directed scenarios plus randomized traffic
// compared against a floor-index reference model.
module tb_call_scheduler;

   localparam int NF = 6;
   localparam int DC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NF-1:0] btn;
   logic [NF-1:0] currentF;
   logic          isOpen;
   logic [NF-1:0] requestF;
   logic [NF-1:0] desF;
   logic [1:0]    up;
   logic          isClose;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [NF-1:0] m_pend;
   int            m_dir;   // 0 idle, 1 up, 2 down
   logic [NF-1:0] m_req;
   logic [NF-1:0] m_des;
   logic [1:0]    m_up;
   logic          m_close;
   int            m_cnt;
   logic [NF-1:0] m_prev;

   call_scheduler #(.NF(NF), .DOOR_CYCLES(DC)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn),
      .currentF (currentF),
      .isOpen   (isOpen),
      .requestF (requestF),
      .desF     (desF),
      .up       (up),
      .isClose  (isClose)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pend  = '0;
      m_dir   = 0;
      m_req   = '0;
      m_des   = 6'b000001;
      m_up    = 2'b00;
      m_close = 1'b0;
      m_cnt   = 0;
      m_prev  = '0;
   endtask

   // advance the model by one clock using the inputs currently applied
   task automatic model_step();
      logic [NF-1:0] press;
      logic [NF-1:0] np;
      logic [NF-1:0] one;
      int            k;
      int            ones;
      bit            reopen;
      bit            has_above;
      bit            has_below;
      one   = 6'b000001;
      press = btn & ~m_prev;
      ones  = 0;
      k     = 0;
      for (int i = 0; i < NF; i++) begin
         if (currentF[i]) begin
            ones++;
            k = i;
         end
      end
      np     = m_pend | press;
      reopen = 0;
      if (ones == 1 && isOpen) begin
         np[k]  = 1'b0;
         reopen = press[k];
      end
      m_close = isOpen && !reopen && (m_cnt == DC);
      if (!isOpen || reopen) m_cnt = 0;
      else if (m_cnt < DC)   m_cnt = m_cnt + 1;
      m_pend = np;
      if (ones == 1) begin
         has_above = 0;
         has_below = 0;
         for (int i = 0; i < NF; i++) begin
            if (np[i] && i > k) has_above = 1;
            if (np[i] && i < k) has_below = 1;
         end
         case (m_dir)
            2:       m_dir = has_below ? 2 : (has_above ? 1 : 0);
            default: m_dir = has_above ? 1 : (has_below ? 2 : 0);
         endcase
         m_req = np;
         if (m_dir == 1) begin
            for (int i = NF - 1; i > k; i--) if (np[i]) m_des = one << i;
            m_up = 2'b10;
         end else if (m_dir == 2) begin
            for (int i = 0; i < k; i++) if (np[i]) m_des = one << i;
            m_up = 2'b01;
         end else begin
            m_des = currentF;
            m_up  = 2'b00;
         end
      end
      m_prev = btn;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [14:0] got;
      logic [14:0] exp;
      reset    = 1'b0;
      btn      = 6'b111111;
      currentF = 6'b000001;
      isOpen   = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      got = {requestF, desF, up, isClose};
      exp = {6'b000000, 6'b000001, 2'b00, 1'b0};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL reset_state: got %b expected %b", got, exp);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (requestF !== 6'b000000) begin
         n_fail++;
         $display("FAIL reset_release_held_btn: requestF %b expected 000000", requestF);
      end
      btn = '0;
      step();
      got = {requestF, desF, up, isClose};
      exp = {6'b000000, 6'b000001, 2'b00, 1'b0};
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL reset_first_cycle: got %b expected %b", got, exp);
      end
   endtask

   task automatic test_dwell();
      currentF = 6'b000001;
      isOpen   = 1'b1;
      btn      = '0;
      for (int i = 1; i <= 7; i++) begin
         step();
         n_checks++;
         if ({requestF, desF, up, isClose} !== {6'b0, 6'b000001, 2'b00, (i >= 5)}) begin
            n_fail++;
            $display("FAIL dwell_step%0d: isClose %b desF %b expected isClose %b", i, isClose, desF, (i >= 5));
         end
      end
      isOpen = 1'b0;
      step();
      n_checks++;
      if (isClose !== 1'b0) begin
         n_fail++;
         $display("FAIL dwell_close_drop: isClose %b expected 0", isClose);
      end
   endtask

   task automatic test_press();
      logic [14:0] exp;
      currentF = 6'b000001;
      isOpen   = 1'b0;
      btn      = 6'b001000;
      exp      = {6'b001000, 6'b001000, 2'b10, 1'b0};
      step();
      n_checks++;
      if ({requestF, desF, up, isClose} !== exp) begin
         n_fail++;
         $display("FAIL press_latch: got %b expected %b", {requestF, desF, up, isClose}, exp);
      end
      btn = '0;
      step();
      n_checks++;
      if ({requestF, desF, up, isClose} !== exp) begin
         n_fail++;
         $display("FAIL press_hold: got %b expected %b", {requestF, desF, up, isClose}, exp);
      end
   endtask

   task automatic test_scan();
      logic [NF-1:0] cf_seq  [5] = '{6'b001000, 6'b010000, 6'b100000, 6'b000001, 6'b000001};
      logic          op_seq  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [NF-1:0] bt_seq  [5] = '{6'b110001, 6'b0, 6'b0, 6'b0, 6'b0};
      logic [NF-1:0] req_exp [5] = '{6'b110001, 6'b100001, 6'b000001, 6'b000000, 6'b000000};
      logic [NF-1:0] des_exp [5] = '{6'b010000, 6'b100000, 6'b000001, 6'b000001, 6'b000001};
      logic [1:0]    up_exp  [5] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b00};
      for (int i = 0; i < 5; i++) begin
         currentF = cf_seq[i];
         isOpen   = op_seq[i];
         btn      = bt_seq[i];
         step();
         n_checks++;
         if ({requestF, desF, up} !== {req_exp[i], des_exp[i], up_exp[i]}) begin
            n_fail++;
            $display("FAIL scan_step%0d: req %b des %b up %b expected req %b des %b up %b",
                     i, requestF, desF, up, req_exp[i], des_exp[i], up_exp[i]);
         end
      end
   endtask

   task automatic test_hold_serve();
      currentF = 6'b000001;
      isOpen   = 1'b0;
      btn      = 6'b000100;
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if ({requestF, desF, up} !== {6'b000100, 6'b000100, 2'b10}) begin
            n_fail++;
            $display("FAIL hold_once_step%0d: req %b des %b up %b expected 000100 000100 10", i, requestF, desF, up);
         end
      end
      btn      = '0;
      currentF = 6'b000100;
      isOpen   = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         n_checks++;
         if ({requestF, up, isClose} !== {6'b0, 2'b00, (i >= 5)}) begin
            n_fail++;
            $display("FAIL serve_dwell_step%0d: req %b up %b isClose %b expected 000000 00 %b", i, requestF, up, isClose, (i >= 5));
         end
      end
      btn = 6'b000100;
      step();
      n_checks++;
      if ({requestF, isClose} !== {6'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reopen_race: req %b isClose %b expected 000000 0", requestF, isClose);
      end
      btn = '0;
      for (int i = 1; i <= 5; i++) begin
         step();
         n_checks++;
         if ({requestF, isClose} !== {6'b0, (i >= 5)}) begin
            n_fail++;
            $display("FAIL reopen_dwell_step%0d: req %b isClose %b expected 000000 %b", i, requestF, isClose, (i >= 5));
         end
      end
      isOpen = 1'b0;
      step();
   endtask

   task automatic test_async_reset();
      logic [14:0] exp;
      currentF = 6'b000001;
      isOpen   = 1'b0;
      btn      = 6'b011010;
      step();
      exp = {6'b011010, 6'b000010, 2'b10, 1'b0};
      n_checks++;
      if ({requestF, desF, up, isClose} !== exp) begin
         n_fail++;
         $display("FAIL async_setup: got %b expected %b", {requestF, desF, up, isClose}, exp);
      end
      btn = '0;
      step();
      #2;
      reset = 1'b0;
      #1;
      exp = {6'b000000, 6'b000001, 2'b00, 1'b0};
      n_checks++;
      if ({requestF, desF, up, isClose} !== exp) begin
         n_fail++;
         $display("FAIL async_reset_immediate: got %b expected %b", {requestF, desF, up, isClose}, exp);
      end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      step();
      n_checks++;
      if ({requestF, desF, up, isClose} !== exp) begin
         n_fail++;
         $display("FAIL async_reset_after: got %b expected %b", {requestF, desF, up, isClose}, exp);
      end
   endtask

   task automatic test_random();
      logic [NF-1:0] one;
      int            r;
      one = 6'b000001;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            r = int'($urandom_range(0, 19));
            if (r == 0)      currentF = '0;
            else if (r == 1) currentF = 6'($urandom);
            else             currentF = one << $urandom_range(0, NF - 1);
         end
         if ($urandom_range(0, 4) == 0) isOpen = ~isOpen;
         for (int i = 0; i < NF; i++) btn[i] = ($urandom_range(0, 7) == 0);
         step();
         n_checks++;
         if ({requestF, desF, up, isClose} !== {m_req, m_des, m_up, m_close}) begin
            n_fail++;
            $display("FAIL random_cycle%0d: req %b des %b up %b close %b expected req %b des %b up %b close %b",
                     n, requestF, desF, up, isClose, m_req, m_des, m_up, m_close);
         end
      end
   endtask

   initial begin
      reset    = 1'b0;
      btn      = '0;
      currentF = 6'b000001;
      isOpen   = 1'b0;
      model_reset();
      test_reset();
      test_dwell();
      test_press();
      test_scan();
      test_hold_serve();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
